// File: rtl/nios_system_sw_pkg.sv
// Shared constants and types for the slide-switch conditioning path.
package nios_system_sw_pkg;

   localparam int unsigned SW_WIDTH              = 10;
   localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 500000;
   localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

   // What the per-bit debouncer does on the current edge.
   typedef enum logic [1:0] {
      DB_IDLE   = 2'd0,  // synchronized level matches clean level
      DB_COUNT  = 2'd1,  // level differs, still below threshold
      DB_COMMIT = 2'd2   // level differed long enough, take it
   } db_action_e;

endpackage

// File: rtl/nios_system_sw_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter, clean flop and
// one-cycle rise/fall pulse flops.
module nios_system_sw_debounce_bit
   import nios_system_sw_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_clean,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   db_action_e       act;

   // Classify this edge: matching level, still counting, or commit.
   always_comb begin
      act = DB_IDLE;
      if (sync2 != sw_clean) begin
         if (cnt == CNT_LAST) act = DB_COMMIT;
         else                 act = DB_COUNT;
      end
   end

   // Synchronizer, counter, clean level and pulses, all cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         sw_clean <= 1'b0;
         sw_rise  <= 1'b0;
         sw_fall  <= 1'b0;
      end else begin
         sync1   <= sw_raw;
         sync2   <= sync1;
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
         case (act)
            DB_COUNT: cnt <= cnt + CNT_W'(1);
            DB_COMMIT: begin
               cnt      <= '0;
               sw_clean <= sync2;
               sw_rise  <= sync2;
               sw_fall  <= ~sync2;
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: rtl/nios_system_sw_debounce.sv
// Debounces the raw slide-switch vector before it reaches the switch PIO.
// Each bit is handled independently; the top only merges the edge pulses.
module nios_system_sw_debounce
   import nios_system_sw_pkg::*;
#(
   parameter int unsigned WIDTH         = SW_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   // A one-cycle threshold would leave no room to reject a single glitch.
   if (STABLE_CYCLES < 2) begin : g_bad_low
      $error("nios_system_sw_debounce: STABLE_CYCLES must be at least 2");
   end
   if (STABLE_CYCLES > (1 << 24)) begin : g_bad_high
      $error("nios_system_sw_debounce: STABLE_CYCLES must not exceed 2^24");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios_system_sw_debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clk      (clk),
         .reset    (reset),
         .sw_raw   (sw_raw[i]),
         .sw_clean (sw_clean[i]),
         .sw_rise  (sw_rise[i]),
         .sw_fall  (sw_fall[i])
      );
   end

   // Any registered edge pulse on any bit.
   always_comb begin
      sw_changed = |(sw_rise | sw_fall);
   end

endmodule

// File: tb/tb_nios_system_sw_debounce.sv
// Scoreboard bench for nios_system_sw_debounce with STABLE_CYCLES=4.
module tb_nios_system_sw_debounce;

   localparam int unsigned W = 10;
   localparam int unsigned S = 4;

   typedef struct packed {
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         changed;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw_clean, sw_rise, sw_fall;
   logic         sw_changed;

   int unsigned  vectors = 0;
   int unsigned  miscompares = 0;
   bit           stim_done = 1'b0;

   exp_t         exp_q[$];

   // Reference: sample history of the pins and a window of the last S levels
   // the debouncer saw.
   logic [W-1:0] samp[$];
   logic [W-1:0] win[$];
   logic [W-1:0] m_clean = '0;
   logic [W-1:0] cur = '0;

   nios_system_sw_debounce #(
      .WIDTH         (W),
      .STABLE_CYCLES (S)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .sw_clean   (sw_clean),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   // Expected outputs after the coming edge, given the pins and reset at it.
   task automatic model_edge(input logic [W-1:0] r, input logic rs);
      exp_t         e;
      logic [W-1:0] obs, upd, nclean;
      bit           all_diff;
      if (rs) begin
         samp.delete();
         samp.push_back('0);
         samp.push_back('0);
         win.delete();
         m_clean = '0;
         e = '0;
         exp_q.push_back(e);
         return;
      end
      // The level judged at this edge is the pin value from two edges back.
      obs = samp[samp.size() - 2];
      samp.push_back(r);
      if (samp.size() > 4) void'(samp.pop_front());
      win.push_back(obs);
      if (win.size() > S) void'(win.pop_front());
      upd = '0;
      if (win.size() == S) begin
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < S; k++)
               if (win[k][b] == m_clean[b]) all_diff = 1'b0;
            upd[b] = all_diff;
         end
      end
      nclean    = m_clean ^ upd;
      e.clean   = nclean;
      e.rise    = upd & nclean;
      e.fall    = upd & ~nclean;
      e.changed = |upd;
      m_clean   = nclean;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [W-1:0] r, input logic rs);
      @(negedge clk);
      sw_raw = r;
      reset  = rs;
      model_edge(r, rs);
   endtask

   task automatic hold(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(cur, 1'b0);
   endtask

   task automatic set_bit(input int unsigned b, input logic v, input int unsigned n);
      cur[b] = v;
      hold(n);
   endtask

   // Monitor: compare DUT outputs one step after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (sw_clean !== e.clean) begin
               miscompares++;
               $display("FAIL clean t=%0t got %h want %h", $time, sw_clean, e.clean);
            end
            vectors++;
            if (sw_rise !== e.rise) begin
               miscompares++;
               $display("FAIL rise t=%0t got %h want %h", $time, sw_rise, e.rise);
            end
            vectors++;
            if (sw_fall !== e.fall) begin
               miscompares++;
               $display("FAIL fall t=%0t got %h want %h", $time, sw_fall, e.fall);
            end
            vectors++;
            if (sw_changed !== e.changed) begin
               miscompares++;
               $display("FAIL changed t=%0t got %b want %b", $time, sw_changed, e.changed);
            end
         end
      end
   end

   // Stimulus: directed scenarios, then random bouncing pins with resets.
   initial begin
      samp.push_back('0);
      samp.push_back('0);

      // Reset held with all switches up, then release.
      cur = 10'h3FF;
      for (int i = 0; i < 3; i++) step(cur, 1'b1);
      hold(10);

      // Clean step on bit 0 from an all-zero start.
      cur = '0;
      step(cur, 1'b1);
      hold(8);
      set_bit(0, 1'b1, 10);

      // Bit 3 bounces and settles back low.
      set_bit(3, 1'b1, 2);
      set_bit(3, 1'b0, 2);
      set_bit(3, 1'b1, 2);
      set_bit(3, 1'b0, 10);

      // Bit 5 bounces then settles high.
      set_bit(5, 1'b1, 3);
      set_bit(5, 1'b0, 1);
      set_bit(5, 1'b1, 10);

      // Bits 2 and 9 rise together, then fall together.
      cur[2] = 1'b1; cur[9] = 1'b1; hold(10);
      cur[2] = 1'b0; cur[9] = 1'b0; hold(10);

      // Reset while bit 7 is mid-count, then release with bit 7 still high.
      set_bit(7, 1'b1, 4);
      step(cur, 1'b1);
      step(cur, 1'b1);
      hold(10);

      // Random pins: per-bit toggles with occasional long holds and resets.
      for (int unsigned n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(cur, 1'b1);
         end else begin
            for (int b = 0; b < W; b++)
               if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            step(cur, 1'b0);
            if ($urandom_range(0, 15) == 0) hold($urandom_range(4, 8));
         end
      end
      hold(8);

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
